instr_fetch_unit: RTL and testbench

Front-end fetch stage sitting directly upstream of InstrMem. It owns the fetch PC, drives InstrMem's word address, and captures the returned instruction words into a small prefetch queue. It hands instructions with their PC to decode over a valid/ready handshake. Decode or execute can redirect it (branch or jump), which flushes the queue.

---
 rtl/cpu_defs_pkg.sv | 11 +
 rtl/fetch_queue.sv | 78 +++++++
 rtl/instr_fetch_unit.sv | 88 ++++++++
 tb/tb_instr_fetch_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// cpu_defs: constants shared by the fetch front end.
//   WordSizeDef : default width of PC, address and instruction words
//   ResetPCDef  : default fetch PC after reset
//   PcIncr      : byte distance between consecutive instruction words
package cpu_defs;

  localparam int              WordSizeDef = 32;
  localparam logic [31:0]     ResetPCDef  = 32'h0000_0000;
  localparam int              PcIncr      = 4;

endpackage : cpu_defs

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {instruction, pc} pairs feeding decode.
// Ports:
//   CLK, RESET_N   : clock, asynchronous active-low reset (clears all storage)
//   i_flush        : drop every entry, pointers and count back to 0
//   i_push         : write {i_wr_instr, i_wr_pc} at the tail
//   i_pop          : retire the head entry
//   o_head_instr   : instruction word at the head (combinational read)
//   o_head_pc      : PC at the head (combinational read)
//   o_count        : occupancy, 0..QDepth
module fetch_queue #(
  parameter  int QDepth   = 4,
  parameter  int WordSize = 32,
  localparam int PtrW     = $clog2(QDepth),
  localparam int CntW     = PtrW + 1
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                i_flush,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [WordSize-1:0] i_wr_instr,
  input  logic [WordSize-1:0] i_wr_pc,
  output logic [WordSize-1:0] o_head_instr,
  output logic [WordSize-1:0] o_head_pc,
  output logic [CntW-1:0]     o_count
);

  logic [WordSize-1:0] r_instr [QDepth];
  logic [WordSize-1:0] r_pc    [QDepth];
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [CntW-1:0]     r_count;

  logic w_pop;
  logic w_push;

  // Guard both sides locally so the count can never leave 0..QDepth,
  // whatever the caller asks for. A push into a full queue is legal only
  // when the head leaves in the same cycle.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count < CntW'(QDepth)) || w_pop);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < QDepth; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_instr[r_wr_ptr] <= i_wr_instr;
        r_pc[r_wr_ptr]    <= i_wr_pc;
        // QDepth is a power of 2, so natural overflow is the modulo wrap.
        r_wr_ptr          <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  assign o_head_instr = r_instr[r_rd_ptr];
  assign o_head_pc    = r_pc[r_rd_ptr];
  assign o_count      = r_count;

endmodule : fetch_queue

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage in front of InstrMem. Owns the fetch PC,
// reads one word per cycle into a prefetch queue and offers the head entry
// to decode over a valid/ready handshake. A redirect reloads the fetch PC
// and flushes the queue.
// Ports:
//   CLK, RESET_N       : clock, asynchronous active-low reset
//   IM_ADDR            : byte address to InstrMem (the fetch PC itself)
//   IM_DOUT            : word returned by InstrMem in the same cycle
//   REDIRECT           : load REDIRECT_PC (word aligned) and flush the queue
//   REDIRECT_PC        : redirect target byte address
//   ID_READY           : decode takes the head entry this cycle
//   ID_VALID           : head entry present
//   ID_INSTR, ID_PC    : head instruction and its byte address
//   ID_PC4             : ID_PC + 4
//   Q_COUNT            : queue occupancy
module instr_fetch_unit
  import cpu_defs::*;
#(
  parameter  int                   WordSize = WordSizeDef,
  parameter  int                   QDepth   = 4,
  parameter  logic [WordSize-1:0]  ResetPC  = ResetPCDef,
  localparam int                   CntW     = $clog2(QDepth) + 1
) (
  input  logic                CLK,
  input  logic                RESET_N,
  output logic [WordSize-1:0] IM_ADDR,
  input  logic [WordSize-1:0] IM_DOUT,
  input  logic                REDIRECT,
  input  logic [WordSize-1:0] REDIRECT_PC,
  input  logic                ID_READY,
  output logic                ID_VALID,
  output logic [WordSize-1:0] ID_INSTR,
  output logic [WordSize-1:0] ID_PC,
  output logic [WordSize-1:0] ID_PC4,
  output logic [CntW-1:0]     Q_COUNT
);

  localparam logic [WordSize-1:0] PcStep = WordSize'(PcIncr);

  logic [WordSize-1:0] r_fpc;
  logic [CntW-1:0]     w_count;
  logic                w_deq;
  logic                w_enq;
  logic                w_unused_redirect_lsbs;

  // Targets are forced to word alignment; the low bits are dropped.
  assign w_unused_redirect_lsbs = ^REDIRECT_PC[1:0];

  assign ID_VALID = (w_count != '0);
  assign w_deq    = ID_VALID && ID_READY;
  // A full queue still accepts the new word when the head leaves this cycle,
  // which keeps one-per-cycle throughput with decode always ready.
  assign w_enq    = !REDIRECT && ((w_count < CntW'(QDepth)) || w_deq);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_fpc <= ResetPC;
    end else if (REDIRECT) begin
      r_fpc <= {REDIRECT_PC[WordSize-1:2], 2'b00};
    end else if (w_enq) begin
      r_fpc <= r_fpc + PcStep;
    end
  end

  // InstrMem answers within the cycle, so the address is the PC register
  // itself and the word is captured on the same edge that advances the PC.
  assign IM_ADDR = r_fpc;

  fetch_queue #(
    .QDepth   (QDepth),
    .WordSize (WordSize)
  ) u_fetch_queue (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .i_flush      (REDIRECT),
    .i_push       (w_enq),
    .i_pop        (w_deq),
    .i_wr_instr   (IM_DOUT),
    .i_wr_pc      (r_fpc),
    .o_head_instr (ID_INSTR),
    .o_head_pc    (ID_PC),
    .o_count      (w_count)
  );

  assign ID_PC4  = ID_PC + PcStep;
  assign Q_COUNT = w_count;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational InstrMem model
// holding Mem[k] = 32'h1000_0000 + k (k = word index).
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RESET_N;
  logic [31:0] IM_ADDR;
  logic [31:0] IM_DOUT;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        ID_READY;
  logic        ID_VALID;
  logic [31:0] ID_INSTR;
  logic [31:0] ID_PC;
  logic [31:0] ID_PC4;
  logic [2:0]  Q_COUNT;

  int n_vec;
  int n_err;

  instr_fetch_unit #(
    .WordSize (32),
    .QDepth   (4),
    .ResetPC  (32'h0000_0000)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .IM_ADDR     (IM_ADDR),
    .IM_DOUT     (IM_DOUT),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .ID_READY    (ID_READY),
    .ID_VALID    (ID_VALID),
    .ID_INSTR    (ID_INSTR),
    .ID_PC       (ID_PC),
    .ID_PC4      (ID_PC4),
    .Q_COUNT     (Q_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + {2'b00, addr[31:2]};
  endfunction

  assign IM_DOUT = mem_word(IM_ADDR);

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, expv);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_state();
    check_vec("rst_valid", {31'd0, ID_VALID}, 32'd0);
    check_vec("rst_instr", ID_INSTR, 32'd0);
    check_vec("rst_pc",    ID_PC,    32'd0);
    check_vec("rst_pc4",   ID_PC4,   32'd4);
    check_vec("rst_count", {29'd0, Q_COUNT}, 32'd0);
    check_vec("rst_addr",  IM_ADDR,  32'd0);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    RESET_N     = 1'b0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = 32'd0;
    ID_READY    = 1'b1;

    // 1. Reset, then streaming with decode always ready.
    step();
    step();
    check_reset_state();
    RESET_N = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check_vec("t1_valid", {31'd0, ID_VALID}, 32'd1);
      check_vec("t1_pc",    ID_PC,    32'(4 * (k - 1)));
      check_vec("t1_instr", ID_INSTR, 32'h1000_0000 + 32'(k - 1));
      check_vec("t1_count", {29'd0, Q_COUNT}, 32'd1);
    end

    // 2. Fresh reset, decode stalled: queue fills and fetch holds.
    RESET_N  = 1'b0;
    ID_READY = 1'b0;
    #1;
    check_reset_state();
    RESET_N = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check_vec("t2_count", {29'd0, Q_COUNT}, (k < 4) ? 32'(k) : 32'd4);
    end
    check_vec("t2_addr", IM_ADDR, 32'h10);
    check_vec("t2_pc",   ID_PC,   32'h0);

    // 2/4. Release decode: drain in order while refilling at full occupancy,
    // crossing several pointer wraps.
    ID_READY = 1'b1;
    for (int i = 0; i < 25; i++) begin
      check_vec("t4_pc",    ID_PC,    32'(4 * i));
      check_vec("t4_instr", ID_INSTR, 32'h1000_0000 + 32'(i));
      check_vec("t4_pc4",   ID_PC4,   32'(4 * i + 4));
      check_vec("t4_count", {29'd0, Q_COUNT}, 32'd4);
      check_vec("t4_addr",  IM_ADDR,  32'(4 * i + 16));
      step();
    end

    // 3. Redirect to an unaligned target while full.
    ID_READY = 1'b0;
    step();
    check_vec("t3_full", {29'd0, Q_COUNT}, 32'd4);
    check_vec("t3_hold", ID_PC, 32'd100);
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h0000_0203;
    step();
    REDIRECT = 1'b0;
    check_vec("t3_count", {29'd0, Q_COUNT}, 32'd0);
    check_vec("t3_valid", {31'd0, ID_VALID}, 32'd0);
    check_vec("t3_addr",  IM_ADDR, 32'h200);
    // Ready while empty must not disturb the count.
    ID_READY = 1'b1;
    step();
    check_vec("t3_pc",     ID_PC,    32'h200);
    check_vec("t3_instr",  ID_INSTR, 32'h1000_0080);
    check_vec("t3_count1", {29'd0, Q_COUNT}, 32'd1);
    check_vec("t3_valid1", {31'd0, ID_VALID}, 32'd1);

    // 5. Redirect to the top word; PC wraps to 0.
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'hFFFF_FFFC;
    step();
    REDIRECT = 1'b0;
    check_vec("t5_count", {29'd0, Q_COUNT}, 32'd0);
    check_vec("t5_addr",  IM_ADDR, 32'hFFFF_FFFC);
    step();
    check_vec("t5_pc_top",  ID_PC,    32'hFFFF_FFFC);
    check_vec("t5_pc4_top", ID_PC4,   32'h0);
    check_vec("t5_ins_top", ID_INSTR, 32'h4FFF_FFFF);
    check_vec("t5_addr0",   IM_ADDR,  32'h0);
    step();
    check_vec("t5_pc_wrap",  ID_PC,    32'h0);
    check_vec("t5_ins_wrap", ID_INSTR, 32'h1000_0000);
    check_vec("t5_pc4_wrap", ID_PC4,   32'h4);

    // 6. Asynchronous reset between edges mid-stream.
    step();
    step();
    #3;
    RESET_N = 1'b0;
    #1;
    check_vec("t6_valid", {31'd0, ID_VALID}, 32'd0);
    check_vec("t6_count", {29'd0, Q_COUNT}, 32'd0);
    check_vec("t6_addr",  IM_ADDR, 32'h0);
    check_vec("t6_pc",    ID_PC,   32'h0);
    #1;
    RESET_N = 1'b1;
    step();
    check_vec("t6_resume_pc",    ID_PC,    32'h0);
    check_vec("t6_resume_instr", ID_INSTR, 32'h1000_0000);
    check_vec("t6_resume_valid", {31'd0, ID_VALID}, 32'd1);
    step();
    check_vec("t6_next_pc", ID_PC, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_instr_fetch_unit
